// File: rtl/halflife_pkg.sv
// Shared types for the half-life decay sequencer: FSM states and the
// one-hot command encoding driven onto the counter's up/down/load pins.
package halflife_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STEP,
    DONE
  } state_t;

  localparam int CMD_W = 3;
  typedef logic [CMD_W-1:0] cmd_t;

  // Bit order matches {load, down, up}; one-hot-or-zero by construction.
  localparam cmd_t CMD_NONE = 3'b000;
  localparam cmd_t CMD_UP   = 3'b001;
  localparam cmd_t CMD_DOWN = 3'b010;
  localparam cmd_t CMD_LOAD = 3'b100;

  function automatic logic is_busy(input state_t s);
    return (s == LOAD) || (s == WAIT) || (s == STEP);
  endfunction

endpackage

// File: rtl/halflife_tick_timer.sv
// Tick prescaler: counts tick strobes while enabled and fires a one-cycle
// expire on the tick that completes a period; a period of 0 behaves as 1.
module halflife_tick_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic          tick,
  input  logic [TW-1:0] period,
  output logic          expire
);

  logic [TW-1:0] count;
  logic [TW-1:0] last;

  assign last   = (period == '0) ? '0 : period - TW'(1);
  assign expire = en && tick && (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (en && tick) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/halflife_seq.sv
// Half-life decay initiator: loads a quantity into the external counter and
// halves it once per timer period with runs of down pulses, tracking a shadow.
module halflife_seq #(
  parameter int N  = 4,
  parameter int TW = 8,
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          inject,
  input  logic          tick_en,
  input  logic [N-1:0]  init_q,
  input  logic [TW-1:0] half_period,
  input  logic [N-1:0]  cnt_out,
  output logic          up,
  output logic          down,
  output logic          load,
  output logic [N-1:0]  load_val,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [HW-1:0] half_lives
);
  import halflife_pkg::*;

  localparam logic [N-1:0] ONE = N'(1);

  state_t        state, state_d;
  cmd_t          cmd_q, cmd_d;
  logic          busy_d, done_d;
  logic [N-1:0]  shadow, shadow_eff, target, init_cap;
  logic [TW-1:0] hp_cap;
  logic          accept, expire, chk_skip, last_down;

  assign accept    = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign last_down = (state == STEP) && ((shadow - ONE) == target);

  // Commands are registered, so the shadow value that the counter will hold
  // after this edge already includes whatever command is on the pins now.
  always_comb begin
    shadow_eff = shadow;
    unique case (cmd_q)
      CMD_UP:   shadow_eff = shadow + ONE;
      CMD_DOWN: shadow_eff = shadow - ONE;
      CMD_LOAD: shadow_eff = init_cap;
      default:  shadow_eff = shadow;
    endcase
  end

  halflife_tick_timer #(
    .TW(TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .en     (state == WAIT),
    .tick   (tick_en),
    .period (hp_cap),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_d = LOAD;
        LOAD:       state_d = (init_cap == '0) ? DONE : WAIT;
        WAIT:       if (expire) state_d = STEP;
        STEP:       if (last_down) state_d = (target == '0) ? DONE : WAIT;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_d = CMD_NONE;
    unique case (state_d)
      LOAD: cmd_d = CMD_LOAD;
      STEP: cmd_d = CMD_DOWN;
      WAIT: if ((state == WAIT) && inject && !expire && (shadow_eff != '1)) cmd_d = CMD_UP;
      default: cmd_d = CMD_NONE;
    endcase
    busy_d = is_busy(state_d);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= CMD_NONE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  assign {load, down, up} = cmd_q;
  assign load_val         = init_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      target     <= '0;
      init_cap   <= '0;
      hp_cap     <= '0;
      err        <= 1'b0;
      half_lives <= '0;
      chk_skip   <= 1'b0;
    end else begin
      shadow   <= shadow_eff;
      // The counter settles one cycle after any command; skip that cycle.
      chk_skip <= (cmd_q != CMD_NONE);
      if (accept) begin
        init_cap <= init_q;
        hp_cap   <= half_period;
      end
      if ((state == WAIT) && (state_d == STEP)) begin
        target <= shadow_eff >> 1;
      end
      if (accept) begin
        err <= 1'b0;
      end else if ((state == WAIT) && !chk_skip && (cnt_out != shadow)) begin
        err <= 1'b1;
      end
      if (accept) begin
        half_lives <= '0;
      end else if (last_down && !abort && (half_lives != '1)) begin
        half_lives <= half_lives + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_halflife_seq.sv
// Bench for halflife_seq: a behavioural up/down/load counter closes the loop,
// and a queue-based halving model predicts the down-pulse runs of each decay.
module tb_halflife_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, inject, tick_en;
  logic [3:0] init_q;
  logic [7:0] half_period;
  logic [3:0] cnt_out, load_val, half_lives;
  logic       up, down, load, busy, done, err;

  logic [3:0] ctr;
  logic       force_en;
  logic [3:0] force_val;

  int n_checks = 0;
  int n_fail   = 0;

  int   runs[$];
  int   gaps[$];
  int   cur_run, gap_ticks, n_loads, n_ups, n_multi;
  logic mon_clear;

  typedef int iq_t[$];

  always #5 clk = ~clk;

  halflife_seq #(.N(4), .TW(8), .HW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .inject      (inject),
    .tick_en     (tick_en),
    .init_q      (init_q),
    .half_period (half_period),
    .cnt_out     (cnt_out),
    .up          (up),
    .down        (down),
    .load        (load),
    .load_val    (load_val),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .half_lives  (half_lives)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ctr <= 4'd0;
    else if (load) ctr <= load_val;
    else if (up)   ctr <= ctr + 4'd1;
    else if (down) ctr <= ctr - 4'd1;
  end

  assign cnt_out = force_en ? force_val : ctr;

  // Records down-pulse run lengths and the ticks seen in WAIT before each run.
  always @(negedge clk) begin
    if (mon_clear) begin
      runs.delete();
      gaps.delete();
      cur_run = 0; gap_ticks = 0; n_loads = 0; n_ups = 0; n_multi = 0;
    end else begin
      if (int'(up) + int'(down) + int'(load) > 1) n_multi++;
      if (load) n_loads++;
      if (up) n_ups++;
      if (down) begin
        if (cur_run == 0) begin
          gaps.push_back(gap_ticks);
          gap_ticks = 0;
        end
        cur_run++;
      end else if (cur_run != 0) begin
        runs.push_back(cur_run);
        cur_run = 0;
      end
      if (busy && !down && !load && tick_en) gap_ticks++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic iq_t model_runs(input int q0);
    iq_t r;
    int  q = q0;
    while (q > 0) begin
      r.push_back(q - q / 2);
      q = q / 2;
    end
    return r;
  endfunction

  // mode: 0 plain, 1 inject held until first down, 2 inject in first WAIT
  // cycle without tick, 3 inject on an expiring first tick, 4 force cnt_out.
  task automatic run_seq(input int init, input int hp, input int prob, input int mode,
                         input int q0, input int exp_ups, input int exp_err, input string tag);
    iq_t exp_r;
    int  exp_hl, per;
    bit  seen, first;
    exp_r  = model_runs(q0);
    exp_hl = (exp_r.size() > 15) ? 15 : exp_r.size();
    per    = (hp == 0) ? 1 : hp;
    mon_clear   = 1'b1;
    init_q      = 4'(init);
    half_period = 8'(hp);
    @(negedge clk); #1 mon_clear = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tick_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " load"}, int'(load), 1);
    chk({tag, " err clr"}, int'(err), 0);
    @(posedge clk); #1;
    chk({tag, " done timing"}, int'(done), (init == 0) ? 1 : 0);
    first = 1'b1; seen = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (down) seen = 1'b1;
      tick_en  = ($urandom_range(1, 100) <= prob);
      inject   = 1'b0;
      force_en = 1'b0;
      if (first && mode == 2) begin inject = 1'b1; tick_en = 1'b0; end
      if (first && mode == 3) begin inject = 1'b1; tick_en = 1'b1; end
      if (mode == 1 && !seen) inject = 1'b1;
      if (mode == 4 && seen && !down) force_en = 1'b1;
      first = 1'b0;
      @(posedge clk); #1;
    end
    tick_en = 1'b0; inject = 1'b0; force_en = 1'b0;
    @(negedge clk); #1;
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " err"}, int'(err), exp_err);
    chk({tag, " half_lives"}, int'(half_lives), exp_hl);
    chk({tag, " count"}, int'(ctr), 0);
    chk({tag, " loads"}, n_loads, 1);
    chk({tag, " ups"}, n_ups, exp_ups);
    chk({tag, " onehot"}, n_multi, 0);
    chk({tag, " load_val"}, int'(load_val), init);
    chk({tag, " nruns"}, runs.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < runs.size(); i++)
      chk($sformatf("%s run%0d", tag, i), runs[i], exp_r[i]);
    chk({tag, " ngaps"}, gaps.size(), exp_r.size());
    for (int i = 0; i < gaps.size(); i++)
      chk($sformatf("%s gap%0d", tag, i), gaps[i], per);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; inject = 1'b0; tick_en = 1'b0;
    init_q = 4'd0; half_period = 8'd0; force_en = 1'b0; force_val = 4'd3;
    mon_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmds", int'({up, down, load}), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    chk("rst half_lives", int'(half_lives), 0);
    chk("rst load_val", int'(load_val), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(12, 3, 100, 0, 12, 0, 0, "hl12");
    run_seq(0,  5, 100, 0, 0,  0, 0, "zero");
    run_seq(15, 0, 100, 0, 15, 0, 0, "hp0");
    run_seq(15, 3, 100, 1, 15, 0, 0, "inj_sat");
    run_seq(8,  3, 100, 2, 9,  1, 0, "inj_one");
    run_seq(8,  1, 100, 3, 8,  0, 0, "inj_drop");
    run_seq(12, 3, 100, 4, 12, 0, 1, "err");
    run_seq(5,  1, 100, 0, 5,  0, 0, "err_clr");
    for (int k = 0; k < 8; k++) begin
      int ri, rh, rp;
      ri = $urandom_range(0, 15);
      rh = $urandom_range(0, 4);
      rp = $urandom_range(30, 100);
      run_seq(ri, rh, rp, 0, ri, 0, 0, $sformatf("rnd%0d", k));
    end

    // Abort on the second down pulse of the second halving.
    mon_clear = 1'b1; init_q = 4'd12; half_period = 8'd1;
    @(negedge clk); #1 mon_clear = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tick_en = 1'b1;
    nd = 0;
    for (int c = 0; c < 200 && nd < 2; c++) begin
      if (down && runs.size() == 1) nd++;
      if (nd < 2) begin @(posedge clk); #1; end
    end
    chk("abort reached", nd, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; tick_en = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort cmds", int'({up, down, load}), 0);
    chk("abort done", int'(done), 0);
    chk("abort half_lives held", int'(half_lives), 1);
    chk("abort err held", int'(err), 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort beats start", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("abort nruns", runs.size(), 2);
    chk("abort run2", (runs.size() > 1) ? runs[1] : -1, 2);
    chk("abort count", int'(ctr), 4);
    chk("abort loads", n_loads, 1);

    // Asynchronous reset while parked in WAIT.
    init_q = 4'd9; half_period = 8'd5; tick_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wait busy", int'(busy), 1);
    chk("wait load_val", int'(load_val), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", int'(busy), 0);
    chk("arst cmds", int'({up, down, load}), 0);
    chk("arst load_val", int'(load_val), 0);
    chk("arst done", int'(done), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/halflife_seq.md
Name: halflife_seq

Overview:
Command-side initiator for the team's up/down/load counter (datapath ports up, down, load, in, out). Drives the counter through a half-life decay:
- loads an initial quantity;
- every half-period of tick_en pulses, issues single-cycle down pulses until the count has halved (floor);
- repeats until the count reaches zero.

It keeps a shadow copy of the count and cross-checks it against the counter's out bus.

Parameters:
N, 4, quantity width; must match the counter's n
TW, 8, half-period timer width
HW, 4, half-life event counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sequence (sampled in IDLE and DONE)
abort  input  1  return to IDLE; highest priority after reset
inject  input  1  request one up pulse (honoured in WAIT only)
tick_en  input  1  timebase strobe, one cycle wide
init_q  input  N  initial quantity, captured on accepted start
half_period  input  TW  ticks per half-life; 0 is treated as 1
cnt_out  input  N  counter out bus
up  output  1  counter increment command
down  output  1  counter decrement command
load  output  1  counter load command
load_val  output  N  counter in bus
busy  output  1  high in LOAD, WAIT and STEP
done  output  1  level, high in DONE
err  output  1  sticky shadow mismatch
half_lives  output  HW  completed halvings; saturates at all-ones

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, shadow 0, timer 0, target 0.
- Command outputs are registered and one-hot-or-zero: never two of up/down/load in one cycle.
- load_val = captured init_q; it is valid whenever load=1 and held otherwise.
- The counter applies a command at the edge ending the cycle it is asserted. The shadow updates at the same edge.

States:
- IDLE:
  - start=1 → capture init_q and half_period; clear err, half_lives and timer → LOAD.
- LOAD (1 cycle):
  - load=1; shadow←init_q.
  - Next state is DONE if init_q==0, else WAIT.
- WAIT:
  - No down or load.
  - On tick_en: if timer==max(half_period,1)-1, then timer←0, target←shadow>>1, → STEP. Otherwise timer+1.
  - inject=1 with shadow<2^N-1 and no expiring tick that cycle → up=1, shadow+1, timer unchanged.
  - inject with shadow at max is ignored (no up).
  - inject on an expiring tick cycle is dropped; the tick wins.
  - Check: if cnt_out≠shadow in any WAIT cycle that is not the first after LOAD/STEP/up, err←1 (sticky). The sequence continues.
- STEP:
  - down=1 every cycle; shadow−1.
  - When shadow−1==target: half_lives+1 (saturating), then → DONE if target==0, else → WAIT.
  - Number of down pulses = shadow−floor(shadow/2) = ceil(shadow/2).
  - tick_en and inject are ignored in STEP; the timer stays 0.
- DONE:
  - done=1; outputs hold.
  - start=1 → recapture and → LOAD, as from IDLE.

Global rules:
- abort=1 in any state → IDLE next cycle, with no command asserted that cycle. err and half_lives are held until the next start. abort beats start.
- start while busy is ignored.
- Reset mid-STEP: commands drop immediately (async). The counter may hold a partial value; no recovery is attempted.

Decomposition:
- Package halflife_pkg:
  - state enum (IDLE, LOAD, WAIT, STEP, DONE);
  - localparam for command encoding (CMD_NONE, CMD_UP, CMD_DOWN, CMD_LOAD), used to guarantee one-hot commands.
- One natural sub-module: halflife_tick_timer. A TW-bit tick_en prescaler with clear and an expire strobe, treating half_period 0 as 1.
- The FSM, shadow, err and half_lives stay in halflife_seq.
- Bench instantiates the existing counter with n=N and connects up/down/load/load_val/cnt_out.

Test Plan:
- init_q=12, half_period=3, tick_en every cycle, reset released → load 1 cycle; then per WAIT of 3 cycles, down pulse runs of 6, 3, 2, 1. Counter goes 12→6→3→1→0, done=1, half_lives=4, err=0.
- init_q=0, start → one load cycle, then DONE in the next cycle, no down pulses, half_lives=0.
- init_q=15 (N=4), half_period=0, tick_en every cycle → WAIT lasts 1 cycle. Down runs of 8, 4, 2, 1. half_lives=4.
- init_q=15, inject held in WAIT → no up is issued (shadow saturated). With init_q=8, one inject → up=1 once, count 9, next STEP issues 5 downs → 4.
- Force cnt_out mismatch (disconnect the counter, drive cnt_out=3 while shadow=6) during WAIT → err=1 and stays 1 through DONE. Next start clears it.
- abort during the 2nd down pulse of a STEP run → IDLE next cycle, no further commands. Separately, assert rst_n=0 mid-WAIT → all outputs 0 immediately, without waiting for a clock edge.
